servant_irq_monitor: RTL

- Simulation-side observer downstream of the servant interrupt sim wrapper.
- Consumes that wrapper's fetch trace (pc_adr/pc_vld), timer_irq, mret and jump strobes.
- Measures timer-interrupt entry latency and handler length per interrupt; pushes one record per completed interrupt into a small FIFO drained by the bench over valid/ready.
- Keeps running statistics: interrupt count, worst-case latency, sticky overflow.

---
 rtl/servant_irq_monitor.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/servant_irq_monitor.sv
// Timer-interrupt latency/handler-length observer for the servant sim wrapper.
// Optional jump counting in the handler: define SERVANT_IRQ_MON_JUMPCNT_EN.
module servant_irq_monitor #(
    parameter logic [31:0] MTVEC      = 32'h0000_0004,
    parameter int          LAT_W      = 16,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic               wb_clk,
    input  logic               wb_rst,
    input  logic [31:0]        i_pc_adr,
    input  logic               i_pc_vld,
    input  logic               i_timer_irq,
    input  logic               i_mret,
    input  logic               i_isjump,
    output logic [3*LAT_W-1:0] o_rec_data,
    output logic               o_rec_vld,
    input  logic               i_rec_rdy,
    output logic [15:0]        o_irq_cnt,
    output logic [LAT_W-1:0]   o_max_lat,
    output logic               o_overflow,
    output logic               o_busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int RW = 3 * LAT_W;
    localparam logic [LAT_W-1:0] CMAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ENTRY,
        HANDLER
    } state_t;

    state_t           state_q;
    logic             irq_q;
    logic             mret_seen_q;
    logic [LAT_W-1:0] lat_q;
    logic [LAT_W-1:0] fetch_q;
    logic [LAT_W-1:0] jump_q;
    logic [15:0]      irq_cnt_q;
    logic [LAT_W-1:0] max_lat_q;

    logic rise;
    logic entry;
    logic done;

    assign rise  = i_timer_irq & ~irq_q;
    assign entry = (state_q == WAIT_ENTRY) && i_pc_vld && (i_pc_adr == MTVEC);
    assign done  = (state_q == HANDLER) && i_pc_vld && mret_seen_q;

    // lat_q freezes once the handler is entered and doubles as the latched latency
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q     <= IDLE;
            irq_q       <= 1'b0;
            mret_seen_q <= 1'b0;
            lat_q       <= '0;
            fetch_q     <= '0;
            irq_cnt_q   <= '0;
            max_lat_q   <= '0;
        end else begin
            irq_q <= i_timer_irq;
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q <= WAIT_ENTRY;
                        lat_q   <= {{(LAT_W-1){1'b0}}, 1'b1};
                    end
                end
                WAIT_ENTRY: begin
                    if (entry) begin
                        state_q     <= HANDLER;
                        fetch_q     <= {{(LAT_W-1){1'b0}}, 1'b1};
                        mret_seen_q <= 1'b0;
                    end else if (lat_q != CMAX) begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                HANDLER: begin
                    if (done) begin
                        state_q <= IDLE;
                        if (irq_cnt_q != 16'hFFFF)
                            irq_cnt_q <= irq_cnt_q + 1'b1;
                        if (lat_q > max_lat_q)
                            max_lat_q <= lat_q;
                    end else begin
                        if (i_pc_vld && fetch_q != CMAX)
                            fetch_q <= fetch_q + 1'b1;
                        if (i_mret)
                            mret_seen_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SERVANT_IRQ_MON_JUMPCNT_EN
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            jump_q <= '0;
        end else if (entry) begin
            jump_q <= '0;
        end else if (state_q == HANDLER && !mret_seen_q && i_isjump
                     && jump_q != CMAX) begin
            jump_q <= jump_q + 1'b1;
        end
    end
`else
    logic unused_isjump;
    assign unused_isjump = i_isjump;
    assign jump_q        = '0;
`endif

    logic [RW-1:0] mem_q [FIFO_DEPTH];
    logic [PW:0]   wr_q;
    logic [PW:0]   rd_q;
    logic          ovf_q;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign pop   = !empty && i_rec_rdy;
    // a pop in the same cycle frees the slot a full FIFO needs
    assign push  = done && (!full || pop);

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q[PW-1:0]] <= {jump_q, fetch_q, lat_q};
                wr_q <= wr_q + 1'b1;
            end
            if (pop)
                rd_q <= rd_q + 1'b1;
            if (done && !push)
                ovf_q <= 1'b1;
        end
    end

    assign o_rec_data = mem_q[rd_q[PW-1:0]];
    assign o_rec_vld  = !empty;
    assign o_irq_cnt  = irq_cnt_q;
    assign o_max_lat  = max_lat_q;
    assign o_overflow = ovf_q;
    assign o_busy     = (state_q != IDLE);

endmodule
